// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end, so the instruction ROM and the
// fetch sequencer agree on field widths, ROM depth and the halt encoding.
//
// Contents:
//   ADDR_WIDTH / UNDEFINED / DATA_WIDTH : instruction field widths
//   COMBINED_DATA                       : full instruction word width
//   CNTR_WIDTH                          : program-counter / ROM address width
//   ROM_DEPTH                           : number of valid ROM words
//   HALT_WORD                           : instruction word that stops fetching
//   fetch_state_e                       : fetch controller states
//   addrInRange()                       : legal-ROM-address test
// ----------------------------------------------------------------------------
package cpu_pkg;

  // The address and data fields must be non-zero for the word to exist at all,
  // so this slice uses a 4+0+4 bit instruction word.
  localparam int ADDR_WIDTH    = 4;
  localparam int UNDEFINED     = 0;
  localparam int DATA_WIDTH    = 4;
  localparam int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH;
  localparam int CNTR_WIDTH    = 5;
  localparam int ROM_DEPTH     = 24;

  localparam logic [COMBINED_DATA-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_e;

  // True when addr names a word that exists in a ROM of the given depth.
  function automatic logic addrInRange(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
// One-entry valid/ready pipeline register with a flush input. The producer
// may load only when free_o is high; the consumer pops the entry by raising
// ready_i while valid_o is high. Flush drops the entry but keeps the payload
// so a downstream observer still sees the last word.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : capture data_i/pc_i this edge (producer guarantees free_o)
//   flush_i    : invalidate the entry; wins over load_i and ready_i
//   ready_i    : consumer accepts the entry this cycle
//   data_i     : word to capture
//   pc_i       : address the word came from
//   data_o     : buffered word
//   pc_o       : buffered address
//   valid_o    : buffer holds a word for the consumer
//   free_o     : buffer may be loaded this cycle (empty or being popped)
// ----------------------------------------------------------------------------
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH    = COMBINED_DATA,
  parameter int PC_WIDTH = CNTR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                flush_i,
  input  logic                ready_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0]    data_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                valid_o,
  output logic                free_o
);

  logic [WIDTH-1:0]    data_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;

  assign free_o  = !valid_q || ready_i;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

  // Flush beats load beats pop; payload only changes on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Program counter and fetch controller for a combinational instruction ROM.
// Drives the ROM address, registers each returned word into a one-entry
// buffer and offers it to decode over valid/ready. Handles jumps with flush,
// an explicit halt word and the end of the ROM.
//
// Build option: define FETCH_WRAP_EN to make the PC wrap from the last ROM
// word back to 0; by default the sequencer drains and halts there instead.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle pulse, begins fetching at 0 from IDLE/HALTED
//   counter      : ROM address (registered PC)
//   rom_data     : ROM word at counter (combinational)
//   instr        : buffered instruction
//   instr_pc     : address instr was fetched from
//   instr_valid  : instr is valid
//   instr_ready  : decode accepts instr this cycle
//   jump_valid   : one-cycle redirect request
//   jump_target  : redirect address
//   halted       : high while halted
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int UNDEFINED     = cpu_pkg::UNDEFINED,
  parameter int CNTR_WIDTH    = cpu_pkg::CNTR_WIDTH,
  parameter int ADDR_WIDTH    = cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
  parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH,
  parameter int ROM_DEPTH     = cpu_pkg::ROM_DEPTH,
  parameter logic [COMBINED_DATA-1:0] HALT_WORD = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [CNTR_WIDTH-1:0]    counter,
  input  logic [COMBINED_DATA-1:0] rom_data,
  output logic [COMBINED_DATA-1:0] instr,
  output logic [CNTR_WIDTH-1:0]    instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     jump_valid,
  input  logic [CNTR_WIDTH-1:0]    jump_target,
  output logic                     halted
);

  import cpu_pkg::*;

  localparam logic [CNTR_WIDTH-1:0] LAST_ADDR = CNTR_WIDTH'(ROM_DEPTH - 1);

  fetch_state_e          state_q, state_d;
  logic [CNTR_WIDTH-1:0] counter_q, counter_d;
  logic                  bufLoad;
  logic                  bufFlush;
  logic                  bufFree;

  fetch_buffer #(
    .WIDTH    (COMBINED_DATA),
    .PC_WIDTH (CNTR_WIDTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (bufLoad),
    .flush_i (bufFlush),
    .ready_i (instr_ready),
    .data_i  (rom_data),
    .pc_i    (counter_q),
    .data_o  (instr),
    .pc_o    (instr_pc),
    .valid_o (instr_valid),
    .free_o  (bufFree)
  );

  assign counter = counter_q;
  assign halted  = (state_q == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Next-state / PC / buffer control. A jump in FETCH or DRAIN overrides any
  // capture; an out-of-range target halts without moving the PC, so counter
  // never leaves the legal ROM range.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    bufLoad   = 1'b0;
    bufFlush  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          counter_d = '0;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH, ST_DRAIN: begin
        if (jump_valid) begin
          bufFlush = 1'b1;
          if (addrInRange(int'(jump_target), ROM_DEPTH)) begin
            counter_d = jump_target;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_HALTED;
          end
        end else if (state_q == ST_FETCH) begin
          if (bufFree) begin
            bufLoad = 1'b1;
            if (rom_data == HALT_WORD) begin
              state_d = ST_DRAIN;
            end else if (counter_q == LAST_ADDR) begin
`ifdef FETCH_WRAP_EN
              counter_d = '0;
`else
              state_d = ST_DRAIN;
`endif
            end else begin
              counter_d = counter_q + 1'b1;
            end
          end
        end else begin
          // The buffer pops itself on ready; halt once the last word leaves.
          if (!instr_valid || instr_ready) begin
            state_d = ST_HALTED;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with a behavioural ROM whose contents
// are rewritten between scenarios. Expected values are hand-derived from the
// fetch behaviour; the FETCH_WRAP_EN macro selects the end-of-ROM expectation.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

  import cpu_pkg::*;

  localparam int CW = CNTR_WIDTH;
  localparam int DW = COMBINED_DATA;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] counter;
  logic [DW-1:0] romData;
  logic [DW-1:0] instr;
  logic [CW-1:0] instrPc;
  logic          instrValid;
  logic          instrReady;
  logic          jumpValid;
  logic [CW-1:0] jumpTarget;
  logic          halted;

  logic [DW-1:0] rom [ROM_DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Combinational ROM; addresses past the end read as zero.
  always_comb begin
    romData = '0;
    if (int'(counter) < ROM_DEPTH) romData = rom[counter];
  end

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .counter     (counter),
    .rom_data    (romData),
    .instr       (instr),
    .instr_pc    (instrPc),
    .instr_valid (instrValid),
    .instr_ready (instrReady),
    .jump_valid  (jumpValid),
    .jump_target (jumpTarget),
    .halted      (halted)
  );

  // Drive all control inputs at once.
  task automatic applyStimulus(input logic st, input logic jv, input int jt, input logic rdy);
    start      = st;
    jumpValid  = jv;
    jumpTarget = CW'(jt);
    instrReady = rdy;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check the full visible output set in one call.
  task automatic checkAll(input string tag, input int expCnt, input int expInstr, input int expPc,
                          input logic expValid, input logic expHalted);
    checkOutput({tag, ".counter"}, 32'(counter), 32'(expCnt));
    checkOutput({tag, ".instr"}, 32'(instr), 32'(expInstr));
    checkOutput({tag, ".instr_pc"}, 32'(instrPc), 32'(expPc));
    checkOutput({tag, ".valid"}, 32'(instrValid), 32'(expValid));
    checkOutput({tag, ".halted"}, 32'(halted), 32'(expHalted));
  endtask

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = DW'(i + 1);

    // Reset
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    #12;
    checkAll("reset", 0, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Start: the start edge only loads the PC, capture begins on the next edge
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkAll("start", 0, 0, 0, 1'b0, 1'b0);

    // Streaming words 0..2 at one per cycle
    for (int k = 0; k < 3; k++) begin
      stepClock();
      checkAll($sformatf("stream%0d", k), k + 1, k + 1, k, 1'b1, 1'b0);
    end

    // Backpressure while instr_pc=2 is valid
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      stepClock();
      checkAll($sformatf("stall%0d", k), 3, 3, 2, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    stepClock();
    checkAll("resume3", 4, 4, 3, 1'b1, 1'b0);
    stepClock();
    checkAll("resume4", 5, 5, 4, 1'b1, 1'b0);

    // Jump to 10 while word 4 is valid and not accepted
    applyStimulus(1'b0, 1'b1, 10, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkAll("jumpFlush", 10, 5, 4, 1'b0, 1'b0);
    stepClock();
    checkAll("jumpLand", 11, 11, 10, 1'b1, 1'b0);

    // Halt word at address 7
    rom[7] = HALT_WORD;
    applyStimulus(1'b0, 1'b1, 6, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOutput("haltJump.valid", 32'(instrValid), 32'(0));
    checkOutput("haltJump.counter", 32'(counter), 32'(6));
    stepClock();
    checkAll("word6", 7, 7, 6, 1'b1, 1'b0);
    stepClock();
    checkAll("haltWord", 7, 32'(HALT_WORD), 7, 1'b1, 1'b0);
    stepClock();
    checkAll("halted", 7, 32'(HALT_WORD), 7, 1'b0, 1'b1);
    stepClock();
    checkAll("haltedHold", 7, 32'(HALT_WORD), 7, 1'b0, 1'b1);
    rom[7] = DW'(8);

    // Restart from HALTED
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkAll("restart", 0, 32'(HALT_WORD), 7, 1'b0, 1'b0);
    stepClock();
    checkAll("restart0", 1, 1, 0, 1'b1, 1'b0);

    // End of ROM
    applyStimulus(1'b0, 1'b1, 22, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOutput("endJump.counter", 32'(counter), 32'(22));
    stepClock();
    checkAll("word22", 23, 23, 22, 1'b1, 1'b0);
    stepClock();
`ifdef FETCH_WRAP_EN
    checkAll("word23", 0, 24, 23, 1'b1, 1'b0);
    stepClock();
    checkAll("wrap0", 1, 1, 0, 1'b1, 1'b0);
`else
    checkAll("word23", 23, 24, 23, 1'b1, 1'b0);
    stepClock();
    checkAll("endHalt", 23, 24, 23, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    stepClock();
    checkAll("restartEnd", 1, 1, 0, 1'b1, 1'b0);
`endif

    // Out-of-range jump halts, PC unchanged
    applyStimulus(1'b0, 1'b1, 30, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkAll("badJump", 1, 1, 0, 1'b0, 1'b1);

    // Start and jump together in HALTED: start wins
    applyStimulus(1'b1, 1'b1, 15, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkAll("startWins", 0, 1, 0, 1'b0, 1'b0);
    stepClock();
    stepClock();
    checkAll("run1", 2, 2, 1, 1'b1, 1'b0);

    // Reset mid-fetch clears outputs without waiting for an edge
    rst = 1'b1;
    #1;
    checkAll("midReset", 0, 0, 0, 1'b0, 1'b0);
    stepClock();
    rst = 1'b0;

    // IDLE ignores jumps and holds
    applyStimulus(1'b0, 1'b1, 5, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkAll("idleJump", 0, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
